spm_enable_sequencer: RTL and testbench

Sequencer that configures the Sancus protected-module controller (`omsp_spm_control`) from a descriptor handshake. It accepts one module layout at a time: text start/stop and data start/stop. It optionally validates the layout, drives the r12–r15 layout words, and issues a single-cycle enable pulse. It then waits for the controller's `enabled` or `violation` indication, or a timeout, and returns a status word. It sits between the boot/loader logic and `omsp_spm_control`.

---
 rtl/spm_enable_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spm_enable_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_enable_sequencer.sv
// Loads one protected-module layout, optionally validates it, pulses the enable
// for the Sancus SPM controller and returns OK / bad layout / timeout / violation.
// Optional build macro: SPM_SEQ_LAYOUT_CHECK_EN turns on the layout sanity check.
module spm_enable_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_txt_start,
    input  logic [15:0] req_txt_stop,
    input  logic [15:0] req_data_start,
    input  logic [15:0] req_data_stop,
    output logic [15:0] spm_r12,
    output logic [15:0] spm_r13,
    output logic [15:0] spm_r14,
    output logic [15:0] spm_r15,
    output logic        spm_enable,
    input  logic        spm_enabled,
    input  logic        spm_violation,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_BAD_LAYOUT = 2'b01;
    localparam logic [1:0] ST_TIMEOUT   = 2'b10;
    localparam logic [1:0] ST_VIOLATION = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0][15:0]  layout_in;
    logic [3:0][15:0]  layout_reg;
    logic [CW-1:0]     cnt_reg;
    logic [1:0]        status_reg;
    logic              accept;
    logic              layout_ok;
    logic              timeout_hit;

    assign accept      = (state_reg == S_IDLE) && req_valid;
    assign timeout_hit = (cnt_reg == '0);

    assign layout_in[0] = req_txt_start;
    assign layout_in[1] = req_txt_stop;
    assign layout_in[2] = req_data_start;
    assign layout_in[3] = req_data_stop;

    // Layout words are only replaced by a newly accepted descriptor.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_layout
            always_ff @(posedge mclk) begin
                if (puc_rst) begin
                    layout_reg[gi] <= 16'h0000;
                end else if (accept) begin
                    layout_reg[gi] <= layout_in[gi];
                end
            end
        end
    endgenerate

    assign spm_r12 = layout_reg[0];
    assign spm_r13 = layout_reg[1];
    assign spm_r14 = layout_reg[2];
    assign spm_r15 = layout_reg[3];

`ifdef SPM_SEQ_LAYOUT_CHECK_EN
    // Stops are exclusive; both ranges must be non-empty and disjoint.
    logic txt_empty;
    logic data_empty;
    logic overlap;
    assign txt_empty  = (layout_reg[0] >= layout_reg[1]);
    assign data_empty = (layout_reg[2] >= layout_reg[3]);
    assign overlap    = (layout_reg[0] < layout_reg[3]) && (layout_reg[2] < layout_reg[1]);
    assign layout_ok  = !txt_empty && !data_empty && !overlap;
`else
    // Layout errors are left to the controller (violation or timeout).
    assign layout_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = layout_ok ? S_PULSE : S_RESP;
            end
            S_PULSE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (spm_violation || spm_enabled || timeout_hit) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = 1'b0;
        spm_enable = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_PULSE: begin
                spm_enable = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Timeout budget: loaded with TIMEOUT_CYCLES, so WAIT lasts TIMEOUT_CYCLES+1 idle cycles.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            cnt_reg <= '0;
        end else if (state_reg == S_PULSE) begin
            cnt_reg <= CW'(TIMEOUT_CYCLES);
        end else if ((state_reg == S_WAIT) && !spm_violation && !spm_enabled && !timeout_hit) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    // Status is captured on the transition into RESP and held until the next result.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            status_reg <= ST_OK;
        end else if ((state_reg == S_CHECK) && !layout_ok) begin
            status_reg <= ST_BAD_LAYOUT;
        end else if (state_reg == S_WAIT) begin
            if (spm_violation) begin
                status_reg <= ST_VIOLATION;
            end else if (spm_enabled) begin
                status_reg <= ST_OK;
            end else if (timeout_hit) begin
                status_reg <= ST_TIMEOUT;
            end
        end
    end

    assign rsp_status = status_reg;

endmodule

// File: tb/tb_spm_enable_sequencer.sv
// Self-checking bench for spm_enable_sequencer: scoreboard of expected statuses,
// one task per scenario, cycle-accurate latency and pulse checks.
module tb_spm_enable_sequencer;

    localparam int T = 16;

`ifdef SPM_SEQ_LAYOUT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_txt_start, req_txt_stop, req_data_start, req_data_stop;
    logic [15:0] spm_r12, spm_r13, spm_r14, spm_r15;
    logic        spm_enable;
    logic        spm_enabled;
    logic        spm_violation;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;
    logic [1:0] sb[$];

    spm_enable_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .mclk          (mclk),
        .puc_rst       (puc_rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_txt_start (req_txt_start),
        .req_txt_stop  (req_txt_stop),
        .req_data_start(req_data_start),
        .req_data_stop (req_data_stop),
        .spm_r12       (spm_r12),
        .spm_r13       (spm_r13),
        .spm_r14       (spm_r14),
        .spm_r15       (spm_r15),
        .spm_enable    (spm_enable),
        .spm_enabled   (spm_enabled),
        .spm_violation (spm_violation),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_status    (rsp_status),
        .busy          (busy)
    );

    always #5 mclk = ~mclk;

    // Called at a negedge with the DUT idle; returns at the negedge of cycle N+1.
    task automatic accept(input logic [15:0] ts, input logic [15:0] te,
                          input logic [15:0] ds, input logic [15:0] de);
        req_txt_start  = ts;
        req_txt_stop   = te;
        req_data_start = ds;
        req_data_stop  = de;
        req_valid      = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        req_valid = 1'b0;
    endtask

    // Steps cycle N+c (c from 1) until rsp_valid; drives the chosen events in cycles ev_first..ev_last.
    task automatic run_until_rsp(input int max_c, input int ev_first, input int ev_last,
                                 input bit ev_en, input bit ev_vio,
                                 output int lat, output int pulses, output int pulse_at);
        int c;
        c = 1;
        pulses = 0;
        pulse_at = -1;
        lat = -1;
        forever begin
            if (rsp_valid) begin
                lat = c;
                spm_enabled = 1'b0;
                spm_violation = 1'b0;
                return;
            end
            if (spm_enable) begin
                pulses++;
                pulse_at = c;
            end
            spm_enabled   = (c >= ev_first && c <= ev_last) ? ev_en  : 1'b0;
            spm_violation = (c >= ev_first && c <= ev_last) ? ev_vio : 1'b0;
            if (c >= max_c) begin
                spm_enabled = 1'b0;
                spm_violation = 1'b0;
                return;
            end
            @(negedge mclk);
            c++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge mclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset_req_ready: got %b need 1", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_vec++; if (spm_enable !== 1'b0) begin n_miss++; $display("FAIL reset_spm_enable: got %b need 0", spm_enable); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
        n_vec++; if (rsp_status !== 2'b00) begin n_miss++; $display("FAIL reset_rsp_status: got %b need 00", rsp_status); end
        n_vec++; if ({spm_r12, spm_r13, spm_r14, spm_r15} !== 64'h0) begin
            n_miss++; $display("FAIL reset_layout: got %h need 0", {spm_r12, spm_r13, spm_r14, spm_r15});
        end
        $display("reset: req_ready=%b busy=%b rsp_valid=%b", req_ready, busy, rsp_valid);
    endtask

    task automatic test_good();
        int lat, pulses, pulse_at;
        logic [1:0] exp;
        accept(16'hA000, 16'hA400, 16'h0500, 16'h0C00);
        sb.push_back(2'b00);
        run_until_rsp(40, 3, 3, 1'b1, 1'b0, lat, pulses, pulse_at);
        exp = sb.pop_front();
        n_vec++; if (lat !== 4) begin n_miss++; $display("FAIL good_latency: got %0d need 4", lat); end
        n_vec++; if (pulses !== 1 || pulse_at !== 2) begin
            n_miss++; $display("FAIL good_pulse: got %0d pulses at %0d need 1 at 2", pulses, pulse_at);
        end
        n_vec++; if (rsp_status !== exp) begin n_miss++; $display("FAIL good_status: got %b need %b", rsp_status, exp); end
        n_vec++; if ({spm_r12, spm_r13, spm_r14, spm_r15} !== 64'hA000_A400_0500_0C00) begin
            n_miss++; $display("FAIL good_layout: got %h need a000a40005000c00", {spm_r12, spm_r13, spm_r14, spm_r15});
        end
        ack();
        n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_miss++; $display("FAIL good_return_idle: got busy=%b ready=%b valid=%b need 0 1 0", busy, req_ready, rsp_valid);
        end
        $display("good: latency=%0d pulses=%0d status=%b", lat, pulses, exp);
    endtask

    task automatic test_bad(input string nm, input logic [15:0] ts, input logic [15:0] te,
                            input logic [15:0] ds, input logic [15:0] de);
        int lat, pulses, pulse_at;
        logic [1:0] exp;
        accept(ts, te, ds, de);
        sb.push_back(CHK ? 2'b01 : 2'b10);
        run_until_rsp(60, 0, 0, 1'b0, 1'b0, lat, pulses, pulse_at);
        exp = sb.pop_front();
        n_vec++; if (lat !== (CHK ? 2 : T + 4)) begin
            n_miss++; $display("FAIL %s_latency: got %0d need %0d", nm, lat, CHK ? 2 : T + 4);
        end
        n_vec++; if (pulses !== (CHK ? 0 : 1)) begin
            n_miss++; $display("FAIL %s_pulses: got %0d need %0d", nm, pulses, CHK ? 0 : 1);
        end
        n_vec++; if (rsp_status !== exp) begin n_miss++; $display("FAIL %s_status: got %b need %b", nm, rsp_status, exp); end
        ack();
        $display("%s: latency=%0d pulses=%0d status=%b", nm, lat, pulses, exp);
    endtask

    task automatic test_timeout();
        int lat, pulses, pulse_at;
        logic [1:0] exp;
        accept(16'hA000, 16'hA400, 16'h0500, 16'h0C00);
        sb.push_back(2'b10);
        run_until_rsp(60, 0, 0, 1'b0, 1'b0, lat, pulses, pulse_at);
        exp = sb.pop_front();
        // WAIT occupies cycles N+3 .. lat-1
        n_vec++; if (lat - 3 !== T + 1) begin n_miss++; $display("FAIL timeout_wait_cycles: got %0d need %0d", lat - 3, T + 1); end
        n_vec++; if (rsp_status !== exp) begin n_miss++; $display("FAIL timeout_status: got %b need %b", rsp_status, exp); end
        ack();
        $display("timeout: wait_cycles=%0d status=%b", lat - 3, exp);
    endtask

    task automatic test_priority();
        int lat, pulses, pulse_at;
        logic [1:0] exp;
        accept(16'hA000, 16'hA400, 16'h0500, 16'h0C00);
        sb.push_back(2'b11);
        run_until_rsp(40, 3, 3, 1'b1, 1'b1, lat, pulses, pulse_at);
        exp = sb.pop_front();
        n_vec++; if (lat !== 4 || rsp_status !== exp) begin
            n_miss++; $display("FAIL prio_both: got lat=%0d status=%b need lat=4 status=%b", lat, rsp_status, exp);
        end
        ack();
        $display("priority both: latency=%0d status=%b", lat, exp);
        accept(16'hA000, 16'hA400, 16'h0500, 16'h0C00);
        sb.push_back(2'b11);
        run_until_rsp(40, 7, 7, 1'b0, 1'b1, lat, pulses, pulse_at);
        exp = sb.pop_front();
        n_vec++; if (lat !== 8 || rsp_status !== exp) begin
            n_miss++; $display("FAIL prio_late_violation: got lat=%0d status=%b need lat=8 status=%b", lat, rsp_status, exp);
        end
        ack();
        $display("late violation: latency=%0d status=%b", lat, exp);
    endtask

    task automatic test_early_ignored();
        int lat, pulses, pulse_at;
        logic [1:0] exp;
        accept(16'hA000, 16'hA400, 16'h0500, 16'h0C00);
        sb.push_back(2'b10);
        run_until_rsp(60, 1, 2, 1'b1, 1'b1, lat, pulses, pulse_at);
        exp = sb.pop_front();
        n_vec++; if (lat !== T + 4 || rsp_status !== exp) begin
            n_miss++; $display("FAIL early_ignored: got lat=%0d status=%b need lat=%0d status=%b", lat, rsp_status, T + 4, exp);
        end
        ack();
        $display("early events: latency=%0d status=%b", lat, exp);
    endtask

    task automatic test_backpressure();
        int lat, pulses, pulse_at;
        logic [1:0] exp;
        accept(16'hA000, 16'hA400, 16'h0500, 16'h0C00);
        sb.push_back(2'b00);
        run_until_rsp(40, 3, 3, 1'b1, 1'b0, lat, pulses, pulse_at);
        exp = sb.pop_front();
        req_txt_start = 16'h1111;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_status !== exp || req_ready !== 1'b0) begin
                n_miss++; $display("FAIL backpressure_hold%0d: got valid=%b status=%b ready=%b need 1 %b 0",
                                   i, rsp_valid, rsp_status, req_ready, exp);
            end
            @(negedge mclk);
        end
        req_valid = 1'b0;
        n_vec++; if (spm_r12 !== 16'hA000) begin n_miss++; $display("FAIL backpressure_r12: got %h need a000", spm_r12); end
        ack();
        $display("backpressure: status=%b held 5 cycles", exp);
    endtask

    task automatic test_back_to_back();
        int lat, pulses, pulse_at;
        logic [1:0] exp;
        accept(16'h8000, 16'h8100, 16'h0200, 16'h0300);
        sb.push_back(2'b11);
        run_until_rsp(40, 4, 4, 1'b0, 1'b1, lat, pulses, pulse_at);
        exp = sb.pop_front();
        n_vec++; if (lat !== 5 || rsp_status !== exp) begin
            n_miss++; $display("FAIL b2b_first: got lat=%0d status=%b need lat=5 status=%b", lat, rsp_status, exp);
        end
        ack();
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready: got %b need 1", req_ready); end
        accept(16'hC000, 16'hC200, 16'h0400, 16'h0480);
        sb.push_back(2'b00);
        run_until_rsp(40, 3, 3, 1'b1, 1'b0, lat, pulses, pulse_at);
        exp = sb.pop_front();
        n_vec++; if (lat !== 4 || rsp_status !== exp || spm_r12 !== 16'hC000 || spm_r15 !== 16'h0480) begin
            n_miss++; $display("FAIL b2b_second: got lat=%0d status=%b r12=%h r15=%h need 4 %b c000 0480",
                               lat, rsp_status, spm_r12, spm_r15, exp);
        end
        ack();
        $display("back-to-back: second status=%b", exp);
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        accept(16'hA000, 16'hA400, 16'h0500, 16'h0C00);
        @(negedge mclk);
        @(negedge mclk);
        @(negedge mclk);
        puc_rst = 1'b1;
        @(negedge mclk);
        puc_rst = 1'b0;
        n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1 || spm_enable !== 1'b0 || rsp_valid !== 1'b0) begin
            n_miss++; $display("FAIL rst_wait_idle: got busy=%b ready=%b en=%b valid=%b need 0 1 0 0",
                               busy, req_ready, spm_enable, rsp_valid);
        end
        n_vec++; if ({spm_r12, spm_r13, spm_r14, spm_r15} !== 64'h0) begin
            n_miss++; $display("FAIL rst_wait_layout: got %h need 0", {spm_r12, spm_r13, spm_r14, spm_r15});
        end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge mclk);
        end
        n_vec++; if (seen !== 1'b0) begin n_miss++; $display("FAIL rst_wait_no_rsp: got response need none"); end
        $display("reset mid-wait: busy=%b response_seen=%b", busy, seen);
    endtask

    initial begin
        puc_rst = 1'b1;
        req_valid = 1'b0;
        req_txt_start = '0; req_txt_stop = '0; req_data_start = '0; req_data_stop = '0;
        spm_enabled = 1'b0;
        spm_violation = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;
        test_reset();
        test_good();
        test_bad("bad_text", 16'hA400, 16'hA000, 16'h0500, 16'h0C00);
        test_bad("overlap", 16'h0500, 16'h0900, 16'h0800, 16'h0C00);
        test_timeout();
        test_priority();
        test_early_ignored();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        n_vec++; if (sb.size() !== 0) begin n_miss++; $display("FAIL scoreboard_drain: got %0d left need 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
